// File: rtl/stepper_key_pkg.sv
// Shared constants and helpers for the stepper controller key conditioning.
// Contents:
//   NUM_KEYS_DEFAULT     - number of push-button channels on the board
//   KEY_RELEASED         - idle pin level of a released (active-low) key
//   DEBOUNCE_10MS_50MHZ  - 10 ms of 50 MHz clock cycles
//   cnt_width()          - width of a counter able to hold 0 .. cycles-1
package stepper_key_pkg;

  localparam int   NUM_KEYS_DEFAULT    = 3;
  localparam logic KEY_RELEASED        = 1'b1;
  localparam int   DEBOUNCE_10MS_50MHZ = 500000;

  // Bits needed to count 0 .. cycles-1; never less than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/stepper_key_debounce_if.sv
// Key bundle between the board pins / key PIO and the debouncer.
// Signals:
//   key_raw     - asynchronous pin levels (driven by the board side)
//   key_clean   - debounced levels, feeds the PIO in_port
//   key_press   - one-cycle strobe per key on released -> pressed
//   key_release - one-cycle strobe per key on pressed -> released
// Modports: master = pin/PIO side, slave = debouncer.
interface stepper_key_debounce_if
  import stepper_key_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEFAULT
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_clean;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output key_raw,
    input  key_clean,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_raw,
    output key_clean,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/stepper_key_debounce_channel.sv
// One key channel: two-flop synchroniser, mismatch counter, clean level
// register and registered press/release strobes.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   key_raw     - asynchronous pin level
//   key_clean   - debounced level
//   key_press   - one-cycle strobe, clean level leaving RELEASED_LEVEL
//   key_release - one-cycle strobe, clean level returning to RELEASED_LEVEL
module key_debounce_channel
  import stepper_key_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic RELEASED_LEVEL  = KEY_RELEASED
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean,
  output logic key_press,
  output logic key_release
);

  localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             clean_r;
  logic             press_r;
  logic             release_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchroniser, debounce counter, clean level and edge strobes.
  // A mismatch between the synchronised input and the clean level counts
  // up; a single matching sample clears the count, so only an unbroken run
  // of DEBOUNCE_CYCLES mismatches flips the clean level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= RELEASED_LEVEL;
      sync2_r   <= RELEASED_LEVEL;
      clean_r   <= RELEASED_LEVEL;
      cnt_r     <= '0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
      if (sync2_r != clean_r) begin
        if (cnt_r == CNT_MAX) begin
          clean_r   <= ~clean_r;
          cnt_r     <= '0;
          // Strobe direction follows the level being left.
          press_r   <= (clean_r == RELEASED_LEVEL);
          release_r <= (clean_r != RELEASED_LEVEL);
        end else begin
          cnt_r     <= cnt_r + CNT_W'(1);
          press_r   <= 1'b0;
          release_r <= 1'b0;
        end
      end else begin
        cnt_r     <= '0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end
    end
  end

  assign key_clean   = clean_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/stepper_key_debounce.sv
// Debounces the stepper controller push buttons before the key PIO so the
// PIO edge capture sees exactly one edge per physical actuation.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   keys       - slave side of the key bundle (raw in, clean level and
//                press/release strobes out)
// Each key gets its own independent key_debounce_channel.
module stepper_key_debounce
  import stepper_key_pkg::*;
#(
  parameter int   NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic RELEASED_LEVEL  = KEY_RELEASED
) (
  input  logic                   clk,
  input  logic                   reset,
  stepper_key_debounce_if.slave  keys
);

  logic [NUM_KEYS-1:0] clean_s;
  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] release_s;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RELEASED_LEVEL  (RELEASED_LEVEL)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (keys.key_raw[i]),
      .key_clean   (clean_s[i]),
      .key_press   (press_s[i]),
      .key_release (release_s[i])
    );
  end

  assign keys.key_clean   = clean_s;
  assign keys.key_press   = press_s;
  assign keys.key_release = release_s;

endmodule

// File: tb/tb_stepper_key_debounce.sv
// Self-checking bench for stepper_key_debounce with DEBOUNCE_CYCLES = 4.
// A window model predicts the outputs: the clean level of a key flips on an
// edge when the synchronised samples of the last D edges all differ from it.
module tb_stepper_key_debounce;

  localparam int NK = 3;
  localparam int D  = 4;

  logic clk;
  logic reset;

  stepper_key_debounce_if #(.NUM_KEYS(NK)) kif ();

  stepper_key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D),
    .RELEASED_LEVEL  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int misc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  logic [NK-1:0] rawq[$];
  logic [NK-1:0] s2q[$];
  logic [NK-1:0] m_clean;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_rel;
  int            cyc = 0;
  int            press_cnt [NK];
  int            rel_cnt   [NK];
  int            press_cyc [NK];
  int            rel_cyc   [NK];

  initial begin
    rawq    = '{3'b111, 3'b111};
    m_clean = 3'b111;
    m_press = 3'b000;
    m_rel   = 3'b000;
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_cyc[i] = 0; rel_cyc[i] = 0;
    end
  end

  // Model update on every edge, then compare the DUT just after the edge.
  always @(posedge clk) begin
    logic [NK-1:0] s2;
    bit all_diff;
    cyc++;
    if (reset) begin
      rawq    = '{3'b111, 3'b111};
      s2q     = {};
      m_clean = 3'b111;
      m_press = 3'b000;
      m_rel   = 3'b000;
    end else begin
      s2 = rawq[rawq.size()-2];
      rawq.push_back(kif.key_raw);
      if (rawq.size() > 4) void'(rawq.pop_front());
      s2q.push_back(s2);
      if (s2q.size() > D) void'(s2q.pop_front());
      m_press = 3'b000;
      m_rel   = 3'b000;
      for (int i = 0; i < NK; i++) begin
        if (s2q.size() == D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) begin
            if (s2q[j][i] == m_clean[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_clean[i] = ~m_clean[i];
            if (m_clean[i] == 1'b0) m_press[i] = 1'b1;
            else                    m_rel[i]   = 1'b1;
          end
        end
      end
    end
    #1;
    check("outputs{clean,press,release}",
          32'({kif.key_clean, kif.key_press, kif.key_release}),
          32'({m_clean, m_press, m_rel}));
    for (int i = 0; i < NK; i++) begin
      if (kif.key_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (kif.key_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  int rem [NK];

  initial begin
    reset       = 1'b1;
    kif.key_raw = 3'b000;
    ticks(3);
    // Reset state with keys held low
    check("reset_clean",   32'(kif.key_clean),   32'h7);
    check("reset_press",   32'(kif.key_press),   32'h0);
    check("reset_release", 32'(kif.key_release), 32'h0);
    check("model_reset_clean", 32'(m_clean), 32'h7);
    reset = 1'b0;
    ticks(5);
    check("rst_hold_clean_e5", 32'(kif.key_clean), 32'h7);
    ticks(1);
    check("rst_hold_clean_e6", 32'(kif.key_clean), 32'h0);
    check("rst_hold_press_e6", 32'(kif.key_press), 32'h7);
    check("model_press_e6",    32'(m_press),       32'h7);
    ticks(1);
    check("rst_hold_press_e7", 32'(kif.key_press), 32'h0);

    // Release all, then clean press on key 0
    kif.key_raw = 3'b111;
    ticks(10);
    kif.key_raw = 3'b110;
    ticks(5);
    check("press0_clean_e5", 32'(kif.key_clean[0]), 32'h1);
    ticks(1);
    check("press0_clean_e6", 32'(kif.key_clean[0]), 32'h0);
    check("press0_press_e6", 32'(kif.key_press), 32'h1);
    check("press0_rel_e6",   32'(kif.key_release), 32'h0);
    ticks(1);
    check("press0_press_e7", 32'(kif.key_press), 32'h0);
    kif.key_raw = 3'b111;
    ticks(10);

    // Bounce on key 1: 0x3, 1x1, 0x3, then 1
    clear_counts();
    kif.key_raw[1] = 1'b0; ticks(3);
    kif.key_raw[1] = 1'b1; ticks(1);
    kif.key_raw[1] = 1'b0; ticks(3);
    kif.key_raw[1] = 1'b1; ticks(10);
    check("bounce_clean1",  32'(kif.key_clean[1]), 32'h1);
    check("bounce_press1",  32'(press_cnt[1]), 32'h0);
    check("bounce_rel1",    32'(rel_cnt[1]),   32'h0);

    // Overlapping presses: key 2 for 20 cycles, key 0 for 10 of them
    clear_counts();
    kif.key_raw = 3'b011; ticks(5);
    kif.key_raw = 3'b010; ticks(10);
    kif.key_raw = 3'b011; ticks(5);
    kif.key_raw = 3'b111; ticks(12);
    check("ovl_press0", 32'(press_cnt[0]), 32'h1);
    check("ovl_rel0",   32'(rel_cnt[0]),   32'h1);
    check("ovl_press2", 32'(press_cnt[2]), 32'h1);
    check("ovl_rel2",   32'(rel_cnt[2]),   32'h1);
    check("ovl_press1", 32'(press_cnt[1]), 32'h0);
    check("ovl_span0",  32'(rel_cyc[0] - press_cyc[0]), 32'd10);
    check("ovl_span2",  32'(rel_cyc[2] - press_cyc[2]), 32'd20);

    // Reset mid-count on key 0
    clear_counts();
    kif.key_raw = 3'b110; ticks(2);
    reset = 1'b1; ticks(2);
    check("midrst_clean0", 32'(kif.key_clean[0]), 32'h1);
    check("midrst_press",  32'(kif.key_press), 32'h0);
    reset = 1'b0;
    ticks(5);
    check("midrst_clean0_e5", 32'(kif.key_clean[0]), 32'h1);
    ticks(1);
    check("midrst_clean0_e6", 32'(kif.key_clean[0]), 32'h0);
    check("midrst_press_e6",  32'(kif.key_press), 32'h1);
    ticks(2);
    check("midrst_press_cnt", 32'(press_cnt[0]), 32'h1);
    kif.key_raw = 3'b111;
    ticks(10);

    // Randomised bouncing on all keys, checked by the model every cycle
    for (int i = 0; i < NK; i++) rem[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (rem[i] == 0) begin
          kif.key_raw[i] = 1'($urandom_range(1, 0));
          rem[i] = int'($urandom_range(9, 1));
        end
        rem[i]--;
      end
      ticks(1);
    end
    kif.key_raw = 3'b111;
    ticks(12);
    check("final_clean", 32'(kif.key_clean), 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
